// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and sizes for the register-file write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_write_arbiter_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int FIFO_DEPTH = 4;

   // One queued register-file write
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

   // Which producer owns the write port this cycle
   typedef enum logic [1:0] {
      SLOT_NONE   = 2'd0,
      SLOT_WB     = 2'd1,
      SLOT_FIFO   = 2'd2,
      SLOT_BYPASS = 2'd3
   } slot_e;

   // One-hot register mask for a destination register
   function automatic logic [NUM_REGS-1:0] onehot_rd(input logic [REG_ADDR_W-1:0] rd);
      logic [NUM_REGS-1:0] m;
      m     = '0;
      m[rd] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Producer-side and register-file-side signals of the write arbiter.
// Latency: n/a (wiring only).
// Backpressure: M-unit stalls on M_READY=0; the pipeline writeback never stalls.
interface regfile_write_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              WB_VALID;
   logic [ADDR_W-1:0] WB_RD;
   logic [DATA_W-1:0] WB_DATA;
   logic              M_VALID;
   logic              M_READY;
   logic [ADDR_W-1:0] M_RD;
   logic [DATA_W-1:0] M_DATA;
   logic              WRITEENABLE;
   logic [ADDR_W-1:0] WRITEADDRESS;
   logic [DATA_W-1:0] WRITEDATA;
   logic [31:0]       PENDING;
   logic              WAW_ERR;

   // Arbiter side
   modport slave (
      input  WB_VALID, WB_RD, WB_DATA, M_VALID, M_RD, M_DATA,
      output M_READY, WRITEENABLE, WRITEADDRESS, WRITEDATA, PENDING, WAW_ERR
   );

   // Producers / register file / hazard unit side
   modport master (
      output WB_VALID, WB_RD, WB_DATA, M_VALID, M_RD, M_DATA,
      input  M_READY, WRITEENABLE, WRITEADDRESS, WRITEDATA, PENDING, WAW_ERR
   );
endinterface

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Synchronous FIFO of pending M-unit register writes, with per-entry visibility.
// Latency: pushed entry is visible at head the cycle after the push.
// Backpressure: full flag; caller must not push when full nor pop when empty.
module regfile_write_arbiter_wb_fifo
   import regfile_write_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CNT_W = PW + 1
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  push,
   input  wb_entry_t             din,
   input  logic                  pop,
   output logic                  full,
   output logic                  empty,
   output logic [CNT_W-1:0]      count,
   output wb_entry_t             head,
   output logic [DEPTH-1:0]      ent_vld,
   output logic [REG_ADDR_W-1:0] ent_rd [DEPTH]
);

   wb_entry_t       mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two)
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // Storage; stale contents after reset are masked by ent_vld
   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // An entry is live when its distance from the read pointer is below the count
   for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      logic [PW-1:0] off;
      assign off        = PW'(g) - rd_ptr;
      assign ent_vld[g] = ({1'b0, off} < count);
      assign ent_rd[g]  = mem[g].rd;
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges pipeline writeback and M-unit results onto the single register-file write port.
// Latency: one cycle from the selecting event to the registered write.
// Backpressure: M_READY drops while the M-result FIFO is full; writeback is never stalled.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int DEPTH  = FIFO_DEPTH,
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DATA_W = XLEN
) (
   input  logic                     CLK,
   input  logic                     RESET,
   regfile_write_arbiter_if.slave   bus
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                  m_ready;
   logic                  m_hs;
   logic                  wb_sel;
   logic                  push;
   logic                  pop;
   slot_e                 slot;
   wb_entry_t             m_entry;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [CNT_W-1:0]      fifo_count;
   wb_entry_t             fifo_head;
   logic [DEPTH-1:0]      ent_vld;
   logic [REG_ADDR_W-1:0] ent_rd [DEPTH];
   logic [NUM_REGS-1:0]   pending;
   logic                  we_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [DATA_W-1:0]     data_q;
   logic                  waw_q;

   // Readiness depends only on registered occupancy; a same-cycle pop does not help
   assign m_ready = !RESET && (fifo_count != CNT_W'(DEPTH));
   assign m_hs    = bus.M_VALID && m_ready;
   assign wb_sel  = bus.WB_VALID && (bus.WB_RD != '0);
   assign m_entry = '{rd: bus.M_RD, data: bus.M_DATA};

   // Slot priority: writeback, then FIFO head, then direct M bypass; x0 targets never write
   always_comb begin
      slot = SLOT_NONE;
      push = 1'b0;
      pop  = 1'b0;
      if (wb_sel) begin
         slot = SLOT_WB;
      end else if (!fifo_empty) begin
         slot = SLOT_FIFO;
         pop  = 1'b1;
      end else if (m_hs && (bus.M_RD != '0)) begin
         slot = SLOT_BYPASS;
      end
      if (m_hs && (bus.M_RD != '0) && (slot != SLOT_BYPASS) && !fifo_full) push = 1'b1;
   end

   regfile_write_arbiter_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLK     (CLK),
      .RESET   (RESET),
      .push    (push),
      .din     (m_entry),
      .pop     (pop),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count),
      .head    (fifo_head),
      .ent_vld (ent_vld),
      .ent_rd  (ent_rd)
   );

   // Registers still owed by queued M results, for the hazard unit
   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_vld[i]) pending = pending | onehot_rd(ent_rd[i]);
      end
   end

   // Registered write port plus sticky write-after-write error
   always_ff @(posedge CLK) begin
      if (RESET) begin
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         waw_q  <= 1'b0;
      end else begin
         we_q   <= (slot != SLOT_NONE);
         addr_q <= '0;
         data_q <= '0;
         case (slot)
            SLOT_WB: begin
               addr_q <= bus.WB_RD;
               data_q <= bus.WB_DATA;
            end
            SLOT_FIFO: begin
               addr_q <= fifo_head.rd;
               data_q <= fifo_head.data;
            end
            SLOT_BYPASS: begin
               addr_q <= bus.M_RD;
               data_q <= bus.M_DATA;
            end
            default: ;
         endcase
         if (wb_sel && pending[bus.WB_RD]) waw_q <= 1'b1;
      end
   end

   assign bus.M_READY      = m_ready;
   assign bus.WRITEENABLE  = we_q;
   assign bus.WRITEADDRESS = addr_q;
   assign bus.WRITEDATA    = data_q;
   assign bus.PENDING      = pending;
   assign bus.WAW_ERR      = waw_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

   logic CLK;
   logic RESET;
   int   tests;
   int   fails;

   regfile_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

   regfile_write_arbiter #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      bus.WB_VALID = 1'b0;
      bus.WB_RD    = '0;
      bus.WB_DATA  = '0;
      bus.M_VALID  = 1'b0;
      bus.M_RD     = '0;
      bus.M_DATA   = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      RESET = 1'b1;
      tick();
      tick();
      tests++;
      if (bus.WRITEENABLE !== 1'b0 || bus.WRITEADDRESS !== 5'd0 || bus.WRITEDATA !== 32'd0) begin
         fails++;
         $display("FAIL reset_port: we=%b addr=%0d data=%h, want 0/0/0",
                  bus.WRITEENABLE, bus.WRITEADDRESS, bus.WRITEDATA);
      end
      tests++;
      if (bus.PENDING !== 32'd0 || bus.M_READY !== 1'b0 || bus.WAW_ERR !== 1'b0) begin
         fails++;
         $display("FAIL reset_status: pending=%h m_ready=%b waw=%b, want 0/0/0",
                  bus.PENDING, bus.M_READY, bus.WAW_ERR);
      end
      RESET = 1'b0;
      #1;
      tests++;
      if (bus.M_READY !== 1'b1) begin
         fails++;
         $display("FAIL reset_release_ready: m_ready=%b, want 1", bus.M_READY);
      end
   endtask

   task automatic test_wb_only();
      bus.WB_VALID = 1'b1; bus.WB_RD = 5'd1; bus.WB_DATA = 32'hA5A5A5A5;
      tick();
      idle_inputs();
      tests++;
      if (bus.WRITEENABLE !== 1'b1 || bus.WRITEADDRESS !== 5'd1 || bus.WRITEDATA !== 32'hA5A5A5A5) begin
         fails++;
         $display("FAIL wb_write: we=%b addr=%0d data=%h, want 1/1/a5a5a5a5",
                  bus.WRITEENABLE, bus.WRITEADDRESS, bus.WRITEDATA);
      end
      tick();
      tests++;
      if (bus.WRITEENABLE !== 1'b0 || bus.WRITEADDRESS !== 5'd0 || bus.WRITEDATA !== 32'd0) begin
         fails++;
         $display("FAIL wb_pulse_end: we=%b addr=%0d data=%h, want 0/0/0",
                  bus.WRITEENABLE, bus.WRITEADDRESS, bus.WRITEDATA);
      end
   endtask

   task automatic test_bypass();
      bus.M_VALID = 1'b1; bus.M_RD = 5'd2; bus.M_DATA = 32'h5A5A5A5A;
      tick();
      idle_inputs();
      tests++;
      if (bus.WRITEENABLE !== 1'b1 || bus.WRITEADDRESS !== 5'd2 || bus.WRITEDATA !== 32'h5A5A5A5A
          || bus.PENDING !== 32'd0) begin
         fails++;
         $display("FAIL bypass: we=%b addr=%0d data=%h pending=%h, want 1/2/5a5a5a5a/0",
                  bus.WRITEENABLE, bus.WRITEADDRESS, bus.WRITEDATA, bus.PENDING);
      end
   endtask

   task automatic test_collision();
      bus.WB_VALID = 1'b1; bus.WB_RD = 5'd3; bus.WB_DATA = 32'h00000001;
      bus.M_VALID  = 1'b1; bus.M_RD  = 5'd4; bus.M_DATA  = 32'h00000002;
      tick();
      idle_inputs();
      tests++;
      if (bus.WRITEENABLE !== 1'b1 || bus.WRITEADDRESS !== 5'd3 || bus.WRITEDATA !== 32'h1
          || bus.PENDING !== 32'h00000010) begin
         fails++;
         $display("FAIL collision_wb: we=%b addr=%0d data=%h pending=%h, want 1/3/1/10",
                  bus.WRITEENABLE, bus.WRITEADDRESS, bus.WRITEDATA, bus.PENDING);
      end
      tick();
      tests++;
      if (bus.WRITEENABLE !== 1'b1 || bus.WRITEADDRESS !== 5'd4 || bus.WRITEDATA !== 32'h2
          || bus.PENDING !== 32'd0) begin
         fails++;
         $display("FAIL collision_m: we=%b addr=%0d data=%h pending=%h, want 1/4/2/0",
                  bus.WRITEENABLE, bus.WRITEADDRESS, bus.WRITEDATA, bus.PENDING);
      end
   endtask

   // Fill the FIFO with r6..r9 behind a continuous writeback to r1
   task automatic fill_fifo();
      logic exp_rdy;
      for (int i = 0; i < 4; i++) begin
         bus.WB_VALID = 1'b1; bus.WB_RD = 5'd1; bus.WB_DATA = 32'h11110000 + i;
         bus.M_VALID  = 1'b1; bus.M_RD  = 5'(6 + i); bus.M_DATA = 32'h100 + i;
         tick();
         exp_rdy = (i != 3);
         tests++;
         if (bus.M_READY !== exp_rdy) begin
            fails++;
            $display("FAIL fill_ready[%0d]: m_ready=%b, want %b", i, bus.M_READY, exp_rdy);
         end
      end
      tests++;
      if (bus.PENDING !== 32'h000003C0) begin
         fails++;
         $display("FAIL fill_pending: pending=%h, want 000003c0", bus.PENDING);
      end
      idle_inputs();
   endtask

   task automatic test_full_drain();
      fill_fifo();
      for (int i = 0; i < 4; i++) begin
         tick();
         tests++;
         if (bus.WRITEENABLE !== 1'b1 || bus.WRITEADDRESS !== 5'(6 + i)
             || bus.WRITEDATA !== 32'h100 + i) begin
            fails++;
            $display("FAIL drain[%0d]: we=%b addr=%0d data=%h, want 1/%0d/%h", i,
                     bus.WRITEENABLE, bus.WRITEADDRESS, bus.WRITEDATA, 6 + i, 32'h100 + i);
         end
         if (i == 0) begin
            tests++;
            if (bus.M_READY !== 1'b1) begin
               fails++;
               $display("FAIL drain_ready: m_ready=%b, want 1", bus.M_READY);
            end
         end
      end
      tick();
      tests++;
      if (bus.WRITEENABLE !== 1'b0 || bus.PENDING !== 32'd0) begin
         fails++;
         $display("FAIL drain_done: we=%b pending=%h, want 0/0", bus.WRITEENABLE, bus.PENDING);
      end
   endtask

   task automatic test_reset_mid_drain();
      fill_fifo();
      tick();
      tests++;
      if (bus.WRITEENABLE !== 1'b1 || bus.WRITEADDRESS !== 5'd6) begin
         fails++;
         $display("FAIL mid_first_pop: we=%b addr=%0d, want 1/6", bus.WRITEENABLE, bus.WRITEADDRESS);
      end
      RESET = 1'b1;
      tick();
      tests++;
      if (bus.WRITEENABLE !== 1'b0 || bus.PENDING !== 32'd0 || bus.M_READY !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset: we=%b pending=%h m_ready=%b, want 0/0/0",
                  bus.WRITEENABLE, bus.PENDING, bus.M_READY);
      end
      RESET = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (bus.WRITEENABLE !== 1'b0 || bus.PENDING !== 32'd0) begin
            fails++;
            $display("FAIL mid_flushed[%0d]: we=%b pending=%h, want 0/0",
                     i, bus.WRITEENABLE, bus.PENDING);
         end
      end
   endtask

   task automatic test_x0_waw();
      // M result to x0: accepted, never written
      bus.M_VALID = 1'b1; bus.M_RD = 5'd0; bus.M_DATA = 32'hDEADBEEF;
      #1;
      tests++;
      if (bus.M_READY !== 1'b1) begin
         fails++;
         $display("FAIL x0_ready: m_ready=%b, want 1", bus.M_READY);
      end
      tick();
      idle_inputs();
      tests++;
      if (bus.WRITEENABLE !== 1'b0 || bus.PENDING !== 32'd0) begin
         fails++;
         $display("FAIL x0_drop: we=%b pending=%h, want 0/0", bus.WRITEENABLE, bus.PENDING);
      end
      // Writeback to x0 leaves the slot free for an M bypass
      bus.WB_VALID = 1'b1; bus.WB_RD = 5'd0; bus.WB_DATA = 32'h12345678;
      bus.M_VALID  = 1'b1; bus.M_RD  = 5'd11; bus.M_DATA = 32'h0000000B;
      tick();
      idle_inputs();
      tests++;
      if (bus.WRITEENABLE !== 1'b1 || bus.WRITEADDRESS !== 5'd11 || bus.WRITEDATA !== 32'hB
          || bus.PENDING !== 32'd0) begin
         fails++;
         $display("FAIL x0_wb_bypass: we=%b addr=%0d data=%h pending=%h, want 1/11/b/0",
                  bus.WRITEENABLE, bus.WRITEADDRESS, bus.WRITEDATA, bus.PENDING);
      end
      // Queue r5 behind a writeback to r1
      bus.WB_VALID = 1'b1; bus.WB_RD = 5'd1; bus.WB_DATA = 32'h000000AA;
      bus.M_VALID  = 1'b1; bus.M_RD  = 5'd5; bus.M_DATA  = 32'h00000055;
      tick();
      idle_inputs();
      tests++;
      if (bus.PENDING !== 32'h00000020 || bus.WAW_ERR !== 1'b0) begin
         fails++;
         $display("FAIL waw_queue: pending=%h waw=%b, want 20/0", bus.PENDING, bus.WAW_ERR);
      end
      // Writeback hits the pending register
      bus.WB_VALID = 1'b1; bus.WB_RD = 5'd5; bus.WB_DATA = 32'h00000077;
      tick();
      idle_inputs();
      tests++;
      if (bus.WAW_ERR !== 1'b1 || bus.WRITEENABLE !== 1'b1 || bus.WRITEADDRESS !== 5'd5
          || bus.WRITEDATA !== 32'h77) begin
         fails++;
         $display("FAIL waw_set: waw=%b we=%b addr=%0d data=%h, want 1/1/5/77",
                  bus.WAW_ERR, bus.WRITEENABLE, bus.WRITEADDRESS, bus.WRITEDATA);
      end
      tick();
      tests++;
      if (bus.WAW_ERR !== 1'b1 || bus.WRITEADDRESS !== 5'd5 || bus.WRITEDATA !== 32'h55) begin
         fails++;
         $display("FAIL waw_pop: waw=%b addr=%0d data=%h, want 1/5/55",
                  bus.WAW_ERR, bus.WRITEADDRESS, bus.WRITEDATA);
      end
      tick();
      tests++;
      if (bus.WAW_ERR !== 1'b1 || bus.WRITEENABLE !== 1'b0) begin
         fails++;
         $display("FAIL waw_sticky: waw=%b we=%b, want 1/0", bus.WAW_ERR, bus.WRITEENABLE);
      end
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      tests++;
      if (bus.WAW_ERR !== 1'b0) begin
         fails++;
         $display("FAIL waw_clear: waw=%b, want 0", bus.WAW_ERR);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      RESET = 1'b1;
      idle_inputs();
      test_reset();
      test_wb_only();
      test_bypass();
      test_collision();
      test_full_drain();
      test_reset_mid_drain();
      test_x0_waw();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
